// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with stall hold, flush bubble, NOP tracking and a saturating bubble counter.
// Ports: clk/rst_n (async active-low); stall_in holds, flush_in loads a bubble (flush beats stall);
// nop_select_in/valid_in form valid_out; control/cond/data/address *_in fields are registered to *_out;
// bubble_count_out counts entered bubbles, saturating, cleared synchronously by bubble_count_clr.
module id_ex_stage_reg #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH   = 4,
    parameter int BUBBLE_CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall_in,
    input  logic                        flush_in,
    input  logic                        nop_select_in,
    input  logic                        valid_in,
    input  logic                        reg_write_enable_in,
    input  logic                        mem_write_enable_in,
    input  logic                        mem_to_reg_select_in,
    input  logic                        alu_src_select_in,
    input  logic                        status_bits_in,
    input  logic                        pc_src_select_in,
    input  logic [3:0]                  alu_control_in,
    input  logic [3:0]                  cond_in,
    input  logic [DATA_WIDTH-1:0]       pc_in,
    input  logic [DATA_WIDTH-1:0]       rn_data_in,
    input  logic [DATA_WIDTH-1:0]       rm_data_in,
    input  logic [DATA_WIDTH-1:0]       imm_in,
    input  logic [REG_ADDR_WIDTH-1:0]   rd_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0]   rn_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0]   rm_addr_in,
    input  logic                        bubble_count_clr,
    output logic                        reg_write_enable_out,
    output logic                        mem_write_enable_out,
    output logic                        mem_to_reg_select_out,
    output logic                        alu_src_select_out,
    output logic                        status_bits_out,
    output logic                        pc_src_select_out,
    output logic [3:0]                  alu_control_out,
    output logic [3:0]                  cond_out,
    output logic [DATA_WIDTH-1:0]       pc_out,
    output logic [DATA_WIDTH-1:0]       rn_data_out,
    output logic [DATA_WIDTH-1:0]       rm_data_out,
    output logic [DATA_WIDTH-1:0]       imm_out,
    output logic [REG_ADDR_WIDTH-1:0]   rd_addr_out,
    output logic [REG_ADDR_WIDTH-1:0]   rn_addr_out,
    output logic [REG_ADDR_WIDTH-1:0]   rm_addr_out,
    output logic                        valid_out,
    output logic [BUBBLE_CNT_WIDTH-1:0] bubble_count_out
);
    localparam int BW = 14 + 4 * DATA_WIDTH + 3 * REG_ADDR_WIDTH;

    logic [BW-1:0]               w_in_bus;
    logic [BW-1:0]               r_bus;
    logic                        r_valid;
    logic [BUBBLE_CNT_WIDTH-1:0] r_cnt;
    logic                        w_load_valid;
    logic                        w_bubble;

    // All payload fields travel as one flat vector so flush/stall/load treat them uniformly.
    assign w_in_bus = {reg_write_enable_in, mem_write_enable_in, mem_to_reg_select_in, alu_src_select_in,
                       status_bits_in, pc_src_select_in, alu_control_in, cond_in,
                       pc_in, rn_data_in, rm_data_in, imm_in, rd_addr_in, rn_addr_in, rm_addr_in};

    assign w_load_valid = valid_in & ~nop_select_in;
    // A bubble is any non-stalled load whose valid ends up 0; flush overrides stall.
    assign w_bubble     = flush_in | (~stall_in & ~w_load_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus   <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (flush_in) begin
                r_bus   <= '0;
                r_valid <= 1'b0;
            end else if (!stall_in) begin
                r_bus   <= w_in_bus;
                r_valid <= w_load_valid;
            end
            if (bubble_count_clr)
                r_cnt <= '0;
            else if (w_bubble && !(&r_cnt))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign {reg_write_enable_out, mem_write_enable_out, mem_to_reg_select_out, alu_src_select_out,
            status_bits_out, pc_src_select_out, alu_control_out, cond_out,
            pc_out, rn_data_out, rm_data_out, imm_out, rd_addr_out, rn_addr_out, rm_addr_out} = r_bus;
    assign valid_out        = r_valid;
    assign bubble_count_out = r_cnt;
endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

ID/EX pipeline register for the ARM pipeline. It sits directly downstream of the control-unit NOP mux: it captures the mux's gated control signals together with the decoded operands, and presents them to the EX stage one cycle later. It supports hazard stall (hold), branch flush (bubble), and NOP-insert tracking through a valid bit, and keeps a saturating bubble counter for pipeline diagnostics.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, operand and immediate fields
- REG_ADDR_WIDTH, 4, register-file address width
- BUBBLE_CNT_WIDTH, 16, width of the bubble counter

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- stall_in  input  1  hazard unit: hold current contents
- flush_in  input  1  branch resolution: load a bubble
- nop_select_in  input  1  same signal that drives the NOP mux select; 1 = the mux inserted a NOP this cycle
- valid_in  input  1  ID stage holds a real instruction
- reg_write_enable_in, mem_write_enable_in, mem_to_reg_select_in, alu_src_select_in, status_bits_in, pc_src_select_in  input  1 each  gated control from the NOP mux
- alu_control_in  input  4  gated ALU op from the NOP mux
- cond_in  input  4  instruction condition field
- pc_in, rn_data_in, rm_data_in, imm_in  input  DATA_WIDTH each  PC and operands
- rd_addr_in, rn_addr_in, rm_addr_in  input  REG_ADDR_WIDTH each  register addresses
- all matching *_out ports (same names with _out, same widths)  output  registered copies to EX
- valid_out  output  1  EX holds a real instruction
- bubble_count_out  output  BUBBLE_CNT_WIDTH  saturating count of bubbles entered
- bubble_count_clr  input  1  synchronous clear of the counter

## Operation
- Each rising edge evaluates one update, in this priority order:
  1. flush_in=1: load a bubble. All control outputs, alu_control_out, cond_out, data fields and address fields go to 0. valid_out=0.
  2. stall_in=1: hold every output register, including valid_out, unchanged.
  3. Otherwise: load every *_in field. valid_out = valid_in & ~nop_select_in.
- If a NOP is loaded (nop_select_in=1), the control fields arrive already zeroed from the mux and are stored as-is. Data and address fields are stored unchanged.
- A bubble enters on any non-stalled edge where the loaded valid_out is 0. This covers:
  - a flush;
  - nop_select_in=1;
  - valid_in=0.
- Bubble counter:
  - bubble_count_clr=1 sets the counter to 0, and clear beats increment.
  - Otherwise the counter increments by 1 when a bubble enters.
  - The counter saturates at all-ones and never wraps.
- A stalled edge never increments the counter.
- flush_in and stall_in together: the flush wins. Stall has no effect that cycle.

## Timing
- Latency: inputs sampled at edge N appear on the outputs after edge N; EX uses them during cycle N+1.
- Outputs come directly from flops, with no combinational paths from inputs to outputs.
- Reset (rst_n=0, asynchronous assert): every output, including valid_out and bubble_count_out, goes to 0 immediately, independent of clk.
- Reset release: loading resumes at the first rising edge with rst_n=1.
- Reset mid-stall: a held instruction is discarded.
- Stall of any length: outputs stay bit-identical for every stalled cycle. The first non-stalled edge loads the current inputs.
- Counter clear and increment are synchronous only; only reset clears the counter asynchronously.

## Test plan
- Reset: drive all inputs to nonzero values, then pulse rst_n low between edges. Required: all outputs read 0 before the next edge, and bubble_count_out=0.
- Pass-through: apply valid_in=1, nop_select_in=0, reg_write_enable_in=1, alu_control_in=4'b0100, rn_data_in=32'h0000_0005, rd_addr_in=4'd3. Required: after one edge, those exact values on the outputs, valid_out=1, counter unchanged.
- Stall: load pc_in=32'h10, then hold stall_in=1 for 3 edges while changing pc_in to 32'h14. Required: pc_out=32'h10 throughout and the counter unchanged. Then release stall. Required: pc_out=32'h14 after the next edge.
- Flush vs stall: with a valid instruction in the register, assert flush_in=1 and stall_in=1 on the same edge. Required: all control and data outputs 0, valid_out=0, counter +1.
- NOP insert: apply nop_select_in=1 with zeroed control inputs and rn_data_in=32'hAA. Required: valid_out=0, all control outputs 0, rn_data_out=32'hAA, counter +1.
- Counter saturation and clear: with BUBBLE_CNT_WIDTH=2, drive 5 consecutive flushes. Required: the count sequence is 1, 2, 3, 3, 3. Then assert bubble_count_clr together with flush_in. Required: count=0.
